// File: rtl/motoro3_line_step_runner.sv
// Step sequencer for one motor phase: presents lcStep to the line-parameter
// calculator, then emits slLen PWM periods of plLen clocks before advancing.
module motoro3_line_step_runner #(
    parameter int unsigned STEP_LAST = 15,
    parameter int unsigned STEP_W    = 4
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       pwmDuty,
    input  logic [15:0]       plLen,
    input  logic [15:0]       slLen,
    output logic [STEP_W-1:0] lcStep,
    output logic              pwmOut,
    output logic              busy,
    output logic              stepDone,
    output logic              roundDone
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state,      w_state_nxt;
    logic [CNT_W-1:0]  r_pl_len,     w_pl_len_nxt;
    logic [CNT_W-1:0]  r_sl_len,     w_sl_len_nxt;
    logic [CNT_W-1:0]  r_duty,       w_duty_nxt;
    logic [CNT_W-1:0]  r_period_cnt, w_period_cnt_nxt;
    logic [CNT_W-1:0]  r_rep_cnt,    w_rep_cnt_nxt;
    logic [STEP_W-1:0] r_lc_step,    w_lc_step_nxt;
    logic              r_pwm,        w_pwm_nxt;
    logic              r_busy,       w_busy_nxt;
    logic              r_step_done,  w_step_done_nxt;
    logic              r_round_done, w_round_done_nxt;

    logic [CNT_W-1:0]  w_pl_eff;
    logic [CNT_W-1:0]  w_duty_eff;
    logic [STEP_W-1:0] w_lc_step_inc;
    logic              w_last_step;
    logic              w_period_end;
    logic              w_step_end;

    // Calculator outputs are sanitised at LOAD: zero period becomes one clock,
    // duty saturates at the period so the line can be held fully high.
    assign w_pl_eff      = (plLen == '0) ? CNT_W'(1) : plLen;
    assign w_duty_eff    = (pwmDuty > w_pl_eff) ? w_pl_eff : pwmDuty;
    assign w_last_step   = (r_lc_step == STEP_W'(STEP_LAST));
    assign w_lc_step_inc = w_last_step ? '0 : r_lc_step + STEP_W'(1);
    assign w_period_end  = (r_period_cnt == r_pl_len - CNT_W'(1));
    assign w_step_end    = w_period_end && (r_rep_cnt == r_sl_len - CNT_W'(1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state      <= S_IDLE;
            r_pl_len     <= '0;
            r_sl_len     <= '0;
            r_duty       <= '0;
            r_period_cnt <= '0;
            r_rep_cnt    <= '0;
            r_lc_step    <= '0;
            r_pwm        <= 1'b0;
            r_busy       <= 1'b0;
            r_step_done  <= 1'b0;
            r_round_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pl_len     <= w_pl_len_nxt;
            r_sl_len     <= w_sl_len_nxt;
            r_duty       <= w_duty_nxt;
            r_period_cnt <= w_period_cnt_nxt;
            r_rep_cnt    <= w_rep_cnt_nxt;
            r_lc_step    <= w_lc_step_nxt;
            r_pwm        <= w_pwm_nxt;
            r_busy       <= w_busy_nxt;
            r_step_done  <= w_step_done_nxt;
            r_round_done <= w_round_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pl_len_nxt     = r_pl_len;
        w_sl_len_nxt     = r_sl_len;
        w_duty_nxt       = r_duty;
        w_period_cnt_nxt = r_period_cnt;
        w_rep_cnt_nxt    = r_rep_cnt;
        w_lc_step_nxt    = r_lc_step;
        w_pwm_nxt        = 1'b0;
        w_step_done_nxt  = 1'b0;
        w_round_done_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pl_len_nxt     = w_pl_eff;
                w_sl_len_nxt     = slLen;
                w_duty_nxt       = w_duty_eff;
                w_period_cnt_nxt = '0;
                w_rep_cnt_nxt    = '0;
                // A step with zero repetitions is consumed here without running.
                if (slLen == '0) begin
                    w_step_done_nxt  = 1'b1;
                    w_round_done_nxt = w_last_step;
                    w_lc_step_nxt    = w_lc_step_inc;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_pwm_nxt        = (r_period_cnt < r_duty);
                w_period_cnt_nxt = r_period_cnt + CNT_W'(1);
                if (w_period_end) begin
                    w_period_cnt_nxt = '0;
                    w_rep_cnt_nxt    = r_rep_cnt + CNT_W'(1);
                    if (w_step_end) begin
                        w_step_done_nxt  = 1'b1;
                        w_round_done_nxt = w_last_step;
                        w_lc_step_nxt    = w_lc_step_inc;
                        w_state_nxt      = S_LOAD;
                    end
                    // Stop only lands on a period boundary, after any step advance.
                    if (stop) begin
                        w_state_nxt = S_IDLE;
                        w_pwm_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    assign lcStep    = r_lc_step;
    assign pwmOut    = r_pwm;
    assign busy      = r_busy;
    assign stepDone  = r_step_done;
    assign roundDone = r_round_done;

endmodule

// File: tb/tb_motoro3_line_step_runner.sv
// Bench for motoro3_line_step_runner: table of PWM configurations plus
// hand-written reset, skip, stop/resume and start+stop sequences.
module tb_motoro3_line_step_runner;

    localparam int unsigned STEP_LAST = 3;

    logic        clk = 1'b0;
    logic        nRst;
    logic        start;
    logic        stop;
    logic [15:0] pwmDuty;
    logic [15:0] plLen;
    logic [15:0] slLen;
    logic [15:0] sl_cfg;
    logic        skip_en;
    logic [3:0]  lcStep;
    logic        pwmOut;
    logic        busy;
    logic        stepDone;
    logic        roundDone;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] step;
        logic       rd;
        bit         chk;
        int         period;
        int         highs;
    } exp_t;

    typedef struct {
        logic [15:0] pl;
        logic [15:0] sl;
        logic [15:0] duty;
        int          period;
        int          highs;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    // Combinational calculator stand-in; optionally zeroes slLen for step 2.
    assign slLen = (skip_en && lcStep == 4'd2) ? 16'd0 : sl_cfg;

    motoro3_line_step_runner #(
        .STEP_LAST(STEP_LAST),
        .STEP_W   (4)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .start    (start),
        .stop     (stop),
        .pwmDuty  (pwmDuty),
        .plLen    (plLen),
        .slLen    (slLen),
        .lcStep   (lcStep),
        .pwmOut   (pwmOut),
        .busy     (busy),
        .stepDone (stepDone),
        .roundDone(roundDone)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int step, input bit rd, input bit chk,
                        input int period, input int highs);
        exp_t e;
        e.step   = 4'(step);
        e.rd     = rd;
        e.chk    = chk;
        e.period = period;
        e.highs  = highs;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        nRst  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick(1);
        nRst = 1'b1;
        tick(1);
    endtask

    // Step monitor: each stepDone pops one expected record; timing and PWM
    // high count are measured over the window since the previous stepDone.
    int cyc = 0;
    int last_cyc = 0;
    int acc = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (stepDone) begin
            if (sb.size() == 0) begin
                check("unexpected_stepDone", 1, 0);
            end else begin
                e = sb.pop_front();
                check("step_lcStep", int'(lcStep), int'(e.step));
                check("step_roundDone", int'(roundDone), int'(e.rd));
                if (e.chk) begin
                    check("step_period", cyc - last_cyc, e.period);
                    check("step_pwm_highs", acc, e.highs);
                end
            end
            last_cyc = cyc;
            acc      = int'(pwmOut);
        end else begin
            if (roundDone) check("stray_roundDone", 1, 0);
            acc += int'(pwmOut);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int highs;
        nRst = 1'b0; start = 1'b0; stop = 1'b0; skip_en = 1'b0;
        pwmDuty = '0; plLen = '0; sl_cfg = '0;

        vecs[0] = '{16'd10, 16'd3, 16'd4,  31, 12};
        vecs[1] = '{16'd10, 16'd3, 16'd0,  31, 0};
        vecs[2] = '{16'd10, 16'd3, 16'd12, 31, 30};
        vecs[3] = '{16'd0,  16'd3, 16'd1,  4,  3};
        vecs[4] = '{16'd5,  16'd2, 16'd5,  11, 10};
        vecs[5] = '{16'd7,  16'd1, 16'd3,  8,  3};

        #1;
        check("rst_lcStep", int'(lcStep), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pwmOut", int'(pwmOut), 0);
        do_reset();

        // Reset asserted in the middle of step 1.
        plLen = 16'd10; sl_cfg = 16'd3; pwmDuty = 16'd4;
        push(1, 1'b0, 1'b0, 0, 0);
        start = 1'b1;
        tick(35);
        check("pre_rst_lcStep", int'(lcStep), 1);
        check("pre_rst_pwmOut", int'(pwmOut), 1);
        nRst = 1'b0;
        #1;
        check("midrun_rst_lcStep", int'(lcStep), 0);
        check("midrun_rst_pwmOut", int'(pwmOut), 0);
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_stepDone", int'(stepDone), 0);
        check("midrun_rst_roundDone", int'(roundDone), 0);
        start = 1'b0;
        tick(1);
        nRst = 1'b1;
        tick(5);
        check("idle_hold_busy", int'(busy), 0);
        check("idle_hold_pwmOut", int'(pwmOut), 0);
        sb.delete();

        // Table of PWM configurations, five steps each across one wrap.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            plLen = vecs[v].pl; sl_cfg = vecs[v].sl; pwmDuty = vecs[v].duty;
            push(1, 1'b0, 1'b0, 0, 0);
            push(2, 1'b0, 1'b1, vecs[v].period, vecs[v].highs);
            push(3, 1'b0, 1'b1, vecs[v].period, vecs[v].highs);
            push(0, 1'b1, 1'b1, vecs[v].period, vecs[v].highs);
            push(1, 1'b0, 1'b1, vecs[v].period, vecs[v].highs);
            start = 1'b1;
            tick(1);
            check("load_busy", int'(busy), 1);
            check("load_lcStep", int'(lcStep), 0);
            tick(1);
            check("run0_pwmOut", int'(pwmOut), 0);
            tick(1);
            check("first_pwm", int'(pwmOut), int'(vecs[v].highs != 0));
            drain(5 * vecs[v].period + 50);
        end

        // Step 2 has zero repetitions and is skipped inside LOAD.
        do_reset();
        plLen = 16'd10; sl_cfg = 16'd3; pwmDuty = 16'd4; skip_en = 1'b1;
        push(1, 1'b0, 1'b0, 0, 0);
        push(2, 1'b0, 1'b1, 31, 12);
        push(3, 1'b0, 1'b1, 1, 0);
        push(0, 1'b1, 1'b1, 31, 12);
        push(1, 1'b0, 1'b1, 31, 12);
        start = 1'b1;
        drain(300);
        skip_en = 1'b0;

        // Stop mid-period: the period completes, then IDLE at the same step.
        do_reset();
        plLen = 16'd10; sl_cfg = 16'd3; pwmDuty = 16'd4;
        start = 1'b1;
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            highs += int'(pwmOut);
        end
        stop = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            highs += int'(pwmOut);
        end
        check("stop_pwm_highs", highs, 4);
        check("stop_busy", int'(busy), 0);
        check("stop_lcStep", int'(lcStep), 0);
        check("stop_pwmOut", int'(pwmOut), 0);

        // Resume: full step from LOAD, so repetition count restarted.
        push(1, 1'b0, 1'b0, 0, 0);
        stop = 1'b0;
        k = 0;
        while (!stepDone && k < 100) begin
            tick(1);
            k++;
        end
        check("resume_latency", k, 32);
        drain(10);

        // Start and stop together in IDLE.
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        tick(5);
        check("startstop_busy", int'(busy), 0);
        check("startstop_pwmOut", int'(pwmOut), 0);
        start = 1'b0;
        stop  = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
